// File: rtl/ifm_addr_pkg.sv
// Shared types, default sizing and lane-slicing helper for the IFM window address generator.
package ifm_addr_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SETUP     = 3'd1,
        ST_RUN       = 3'd2,
        ST_WAIT_CONT = 3'd3,
        ST_END       = 3'd4
    } state_t;

    localparam int unsigned DEF_LANES  = 8;
    localparam int unsigned DEF_ADDR_W = 12;
    localparam int unsigned DEF_DIM_W  = 6;
    localparam int unsigned DEF_K_W    = 3;
    localparam int unsigned DEF_CH_W   = 8;

    // LSB position of a lane inside the packed address bus.
    function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned addr_w);
        return lane * addr_w;
    endfunction

endpackage

// File: rtl/ifm_lane_addr.sv
// One output lane: holds its stride offset and forms the window-origin address and valid bit.
module ifm_lane_addr
    import ifm_addr_pkg::*;
#(
    parameter int unsigned LANE_IDX = 0,
    parameter int unsigned ADDR_W   = DEF_ADDR_W,
    parameter int unsigned DIM_W    = DEF_DIM_W,
    parameter int unsigned K_W      = DEF_K_W,
    parameter int unsigned PW       = DEF_DIM_W + DEF_K_W + $clog2(DEF_LANES) + 1
) (
    input  logic              i_clock,
    input  logic              i_rst,
    input  logic              i_load,
    input  logic [K_W-1:0]    i_stride,
    input  logic [K_W-1:0]    i_ksize,
    input  logic [DIM_W-1:0]  i_len,
    input  logic [PW-1:0]     i_x,
    input  logic [ADDR_W-1:0] i_base,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_valid
);

    logic [PW-1:0] r_off;
    logic [PW-1:0] w_pos;

    always_ff @(posedge i_clock or posedge i_rst) begin
        if (i_rst) begin
            r_off <= '0;
        end else if (i_load) begin
            r_off <= PW'(LANE_IDX) * PW'(i_stride);
        end
    end

    assign w_pos   = i_x + r_off;
    assign o_addr  = i_base + ADDR_W'(w_pos);
    assign o_valid = (w_pos + PW'(i_ksize)) <= PW'(i_len);

endmodule

// File: rtl/ifm_window_addr_gen.sv
// Raster-order IFM window address generator: FSM, position counters, channel passes and handshake.
module ifm_window_addr_gen
    import ifm_addr_pkg::*;
#(
    parameter int unsigned LANES  = DEF_LANES,
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DIM_W  = DEF_DIM_W,
    parameter int unsigned K_W    = DEF_K_W,
    parameter int unsigned CH_W   = DEF_CH_W
) (
    input  logic                     clock,
    input  logic                     rst,
    input  logic                     tile_start,
    input  logic                     tile_continue,
    input  logic [K_W-1:0]           ksize,
    input  logic [K_W-1:0]           stride,
    input  logic [DIM_W-1:0]         tile_length,
    input  logic [DIM_W-1:0]         tile_height,
    input  logic [CH_W-1:0]          num_ch,
    output logic [LANES*ADDR_W-1:0]  base_address,
    output logic [LANES-1:0]         base_addr_valid,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_row_last,
    output logic                     out_pass_last,
    output logic                     addr_gen_done,
    output logic                     ifmap_end,
    output logic                     cfg_err,
    output logic                     busy
);

    localparam int unsigned PW  = DIM_W + K_W + $clog2(LANES) + 1;
    localparam int unsigned AW2 = 2 * DIM_W;
    localparam int unsigned SW  = DIM_W + K_W;

    state_t              r_state;
    logic [K_W-1:0]      r_ksize;
    logic [K_W-1:0]      r_stride;
    logic [DIM_W-1:0]    r_len;
    logic [DIM_W-1:0]    r_hgt;
    logic [CH_W-1:0]     r_nch;
    logic [CH_W-1:0]     r_ch;
    logic [ADDR_W-1:0]   r_area;
    logic [ADDR_W-1:0]   r_ch_base;
    logic [ADDR_W-1:0]   r_row_addr;
    logic [PW-1:0]       r_x;
    logic [PW-1:0]       r_y;
    logic                r_cfg_err;
    logic                r_done;

    logic [PW-1:0]       w_step;
    logic [PW-1:0]       w_x_next;
    logic [PW-1:0]       w_y_next;
    logic [AW2-1:0]      w_area;
    logic [SW-1:0]       w_row_step;
    logic [ADDR_W-1:0]   w_row_base;
    logic                w_row_last;
    logic                w_pass_last;
    logic                w_accept;
    logic                w_last_ch;
    logic                w_cfg_bad;
    logic                w_start_ok;
    logic                w_setup;
    logic [LANES-1:0]    w_lane_vld;

    assign w_step      = PW'(LANES) * PW'(r_stride);
    assign w_x_next    = r_x + w_step;
    assign w_y_next    = r_y + PW'(r_stride);
    assign w_area      = AW2'(r_len) * AW2'(r_hgt);
    assign w_row_step  = SW'(r_stride) * SW'(r_len);
    assign w_row_base  = r_ch_base + r_row_addr;
    assign w_row_last  = (w_x_next + PW'(r_ksize)) > PW'(r_len);
    assign w_pass_last = w_row_last && ((w_y_next + PW'(r_ksize)) > PW'(r_hgt));
    assign w_accept    = out_valid && out_ready;
    assign w_last_ch   = (r_ch + CH_W'(1)) == r_nch;
    assign w_setup     = (r_state == ST_SETUP);

    assign w_cfg_bad  = (ksize == '0) || (stride == '0) || (num_ch == '0)
                     || (PW'(ksize) > PW'(tile_length))
                     || (PW'(ksize) > PW'(tile_height));
    assign w_start_ok = tile_start &&
                        ((r_state == ST_IDLE) || (r_state == ST_END) || (r_state == ST_WAIT_CONT));

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_ksize    <= '0;
            r_stride   <= '0;
            r_len      <= '0;
            r_hgt      <= '0;
            r_nch      <= '0;
            r_ch       <= '0;
            r_area     <= '0;
            r_ch_base  <= '0;
            r_row_addr <= '0;
            r_x        <= '0;
            r_y        <= '0;
            r_cfg_err  <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_cfg_err <= 1'b0;
            r_done    <= 1'b0;
            case (r_state)
                ST_SETUP: begin
                    r_area     <= ADDR_W'(w_area);
                    r_x        <= '0;
                    r_y        <= '0;
                    r_row_addr <= '0;
                    r_ch       <= '0;
                    r_ch_base  <= '0;
                    r_state    <= ST_RUN;
                end
                ST_RUN: begin
                    if (w_accept) begin
                        if (w_pass_last) begin
                            r_done     <= 1'b1;
                            r_x        <= '0;
                            r_y        <= '0;
                            r_row_addr <= '0;
                            r_ch       <= r_ch + CH_W'(1);
                            r_ch_base  <= r_ch_base + r_area;
                            r_state    <= w_last_ch ? ST_END : ST_WAIT_CONT;
                        end else if (w_row_last) begin
                            r_x        <= '0;
                            r_y        <= w_y_next;
                            r_row_addr <= r_row_addr + ADDR_W'(w_row_step);
                        end else begin
                            r_x <= w_x_next;
                        end
                    end
                end
                ST_WAIT_CONT: begin
                    if (tile_continue) begin
                        r_state <= ST_RUN;
                    end
                end
                default: ;
            endcase
            // A start accepted in WAIT_CONT overrides a simultaneous continue.
            if (w_start_ok) begin
                if (w_cfg_bad) begin
                    r_cfg_err <= 1'b1;
                    r_state   <= ST_IDLE;
                end else begin
                    r_ksize  <= ksize;
                    r_stride <= stride;
                    r_len    <= tile_length;
                    r_hgt    <= tile_height;
                    r_nch    <= num_ch;
                    r_state  <= ST_SETUP;
                end
            end
        end
    end

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        logic [ADDR_W-1:0] w_addr;
        logic              w_vld;

        ifm_lane_addr #(
            .LANE_IDX (gi),
            .ADDR_W   (ADDR_W),
            .DIM_W    (DIM_W),
            .K_W      (K_W),
            .PW       (PW)
        ) u_lane (
            .i_clock  (clock),
            .i_rst    (rst),
            .i_load   (w_setup),
            .i_stride (r_stride),
            .i_ksize  (r_ksize),
            .i_len    (r_len),
            .i_x      (r_x),
            .i_base   (w_row_base),
            .o_addr   (w_addr),
            .o_valid  (w_vld)
        );

        assign base_address[lane_lsb(gi, ADDR_W) +: ADDR_W] = w_addr;
        assign w_lane_vld[gi] = w_vld;
    end

    assign out_valid       = (r_state == ST_RUN);
    assign base_addr_valid = out_valid ? w_lane_vld : '0;
    assign out_row_last    = out_valid && w_row_last;
    assign out_pass_last   = out_valid && w_pass_last;
    assign addr_gen_done   = r_done;
    assign ifmap_end       = (r_state == ST_END);
    assign cfg_err         = r_cfg_err;
    assign busy            = (r_state != ST_IDLE) && (r_state != ST_END);

endmodule

// File: tb/tb_ifm_window_addr_gen.sv
// Directed self-checking bench for ifm_window_addr_gen with hand-derived walk expectations.
module tb_ifm_window_addr_gen;

    localparam int LANES  = 8;
    localparam int ADDR_W = 12;
    localparam int DIM_W  = 6;
    localparam int K_W    = 3;
    localparam int CH_W   = 8;

    typedef logic [127:0] v_t;

    logic                    clock = 1'b0;
    logic                    rst;
    logic                    tile_start;
    logic                    tile_continue;
    logic [K_W-1:0]          ksize;
    logic [K_W-1:0]          stride;
    logic [DIM_W-1:0]        tile_length;
    logic [DIM_W-1:0]        tile_height;
    logic [CH_W-1:0]         num_ch;
    logic [LANES*ADDR_W-1:0] base_address;
    logic [LANES-1:0]        base_addr_valid;
    logic                    out_valid;
    logic                    out_ready;
    logic                    out_row_last;
    logic                    out_pass_last;
    logic                    addr_gen_done;
    logic                    ifmap_end;
    logic                    cfg_err;
    logic                    busy;

    ifm_window_addr_gen #(
        .LANES  (LANES),
        .ADDR_W (ADDR_W),
        .DIM_W  (DIM_W),
        .K_W    (K_W),
        .CH_W   (CH_W)
    ) dut (
        .clock           (clock),
        .rst             (rst),
        .tile_start      (tile_start),
        .tile_continue   (tile_continue),
        .ksize           (ksize),
        .stride          (stride),
        .tile_length     (tile_length),
        .tile_height     (tile_height),
        .num_ch          (num_ch),
        .base_address    (base_address),
        .base_addr_valid (base_addr_valid),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_row_last    (out_row_last),
        .out_pass_last   (out_pass_last),
        .addr_gen_done   (addr_gen_done),
        .ifmap_end       (ifmap_end),
        .cfg_err         (cfg_err),
        .busy            (busy)
    );

    always #5 clock = ~clock;

    int n_chk = 0;
    int n_bad = 0;

    logic [LANES*ADDR_W-1:0] cap_addr [0:127];
    logic [LANES-1:0]        cap_mask [0:127];
    logic                    cap_rl   [0:127];
    logic                    cap_pl   [0:127];
    int n_beats, first_valid, n_done, stall_bad, stale_bad, cnt;

    task automatic chk(input string tag, input v_t got, input v_t exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic v_t snap();
        return v_t'({base_address, base_addr_valid, out_row_last, out_pass_last});
    endfunction

    function automatic v_t all_outs();
        return v_t'({base_address, base_addr_valid, out_valid, out_row_last, out_pass_last,
                     addr_gen_done, ifmap_end, cfg_err, busy});
    endfunction

    // 28x28, k=3, s=1: row r, beat c of 4 starts at r*28 + c*8.
    function automatic logic [LANES*ADDR_W-1:0] exp_walk(input int n, input int chofs);
        logic [LANES*ADDR_W-1:0] v;
        int r;
        int c;
        r = n / 4;
        c = n % 4;
        for (int i = 0; i < LANES; i++) v[i*ADDR_W +: ADDR_W] = ADDR_W'(chofs + r*28 + c*8 + i);
        return v;
    endfunction

    task automatic start_tile(input int k, input int s, input int l, input int h, input int nc);
        ksize       = K_W'(k);
        stride      = K_W'(s);
        tile_length = DIM_W'(l);
        tile_height = DIM_W'(h);
        num_ch      = CH_W'(nc);
        tile_start  = 1'b1;
        @(negedge clock);
        tile_start  = 1'b0;
    endtask

    task automatic run_pass(input bit rnd, input bit poke_cont, input int budget);
        v_t hold;
        bit have_hold;
        have_hold = 1'b0;
        hold = '0;
        n_beats = 0; first_valid = -1; n_done = 0; stall_bad = 0; stale_bad = 0;
        for (int j = 0; j < 128; j++) begin
            cap_addr[j] = 'x; cap_mask[j] = 'x; cap_rl[j] = 1'bx; cap_pl[j] = 1'bx;
        end
        for (int cyc = 0; cyc < budget && n_done == 0; cyc++) begin
            @(negedge clock);
            out_ready     = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            tile_continue = poke_cont && (cyc == 3);
            if (have_hold && (snap() !== hold)) stall_bad++;
            have_hold = 1'b0;
            if (!out_valid && (base_addr_valid !== '0)) stale_bad++;
            if (addr_gen_done) n_done++;
            if (out_valid) begin
                if (first_valid < 0) first_valid = cyc;
                if (out_ready) begin
                    if (n_beats < 128) begin
                        cap_addr[n_beats] = base_address;
                        cap_mask[n_beats] = base_addr_valid;
                        cap_rl[n_beats]   = out_row_last;
                        cap_pl[n_beats]   = out_pass_last;
                    end
                    n_beats++;
                end else begin
                    hold = snap();
                    have_hold = 1'b1;
                end
            end
        end
        tile_continue = 1'b0;
        out_ready = 1'b1;
        chk("pass_done_seen", v_t'(n_done), v_t'(1));
    endtask

    task automatic check_walk(input string tag, input int chofs);
        chk({tag, "_beats"}, v_t'(n_beats), v_t'(104));
        for (int n = 0; n < 104; n++) begin
            chk({tag, "_addr"}, v_t'(cap_addr[n]), v_t'(exp_walk(n, chofs)));
            chk({tag, "_tags"}, v_t'({cap_rl[n], cap_pl[n], cap_mask[n]}),
                v_t'({(n % 4) == 3, n == 103, ((n % 4) == 3) ? 8'h03 : 8'hFF}));
        end
    endtask

    task automatic cfg_err_case(input string tag, input int k, input int s, input int l);
        start_tile(k, s, l, 28, 1);
        chk({tag, "_pulse"}, v_t'(cfg_err), v_t'(1));
        chk({tag, "_busy"}, v_t'(busy), v_t'(0));
        cnt = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clock);
            if (out_valid || busy || cfg_err) cnt++;
        end
        chk({tag, "_quiet"}, v_t'(cnt), v_t'(0));
    endtask

    initial begin
        rst = 1'b1; tile_start = 1'b0; tile_continue = 1'b0; out_ready = 1'b1;
        ksize = '0; stride = '0; tile_length = '0; tile_height = '0; num_ch = '0;
        repeat (2) @(negedge clock);
        chk("reset_outs", all_outs(), v_t'(0));
        rst = 1'b0;
        @(negedge clock);

        // Basic walk
        start_tile(3, 1, 28, 28, 1);
        chk("setup_busy", v_t'(busy), v_t'(1));
        chk("setup_novalid", v_t'(out_valid), v_t'(0));
        run_pass(1'b0, 1'b0, 300);
        chk("basic_start_lat", v_t'(first_valid), v_t'(0));
        chk("basic_b3_l1", v_t'(cap_addr[3][1*ADDR_W +: ADDR_W]), v_t'(25));
        chk("basic_b4_l0", v_t'(cap_addr[4][0 +: ADDR_W]), v_t'(28));
        check_walk("basic", 0);
        chk("basic_ifmap_end", v_t'(ifmap_end), v_t'(1));
        chk("basic_busy_end", v_t'(busy), v_t'(0));
        cnt = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            if (addr_gen_done || !ifmap_end) cnt++;
        end
        chk("basic_done_once", v_t'(cnt), v_t'(0));

        // Stride 2, k=2, 8x8
        start_tile(2, 2, 8, 8, 1);
        run_pass(1'b0, 1'b0, 100);
        chk("s2_beats", v_t'(n_beats), v_t'(4));
        for (int n = 0; n < 4; n++) begin
            logic [LANES*ADDR_W-1:0] ev;
            for (int i = 0; i < LANES; i++) ev[i*ADDR_W +: ADDR_W] = ADDR_W'(16*n + 2*i);
            chk("s2_addr", v_t'(cap_addr[n]), v_t'(ev));
            chk("s2_tags", v_t'({cap_rl[n], cap_pl[n], cap_mask[n]}), v_t'({1'b1, n == 3, 8'h0F}));
        end

        // Multi-channel with stray continue pulses during RUN
        start_tile(3, 1, 28, 28, 3);
        for (int p = 0; p < 3; p++) begin
            run_pass(1'b0, 1'b1, 300);
            chk("mc_start_lat", v_t'(first_valid), v_t'(0));
            check_walk("mc", p * 784);
            if (p < 2) begin
                chk("mc_no_end", v_t'(ifmap_end), v_t'(0));
                chk("mc_wait_busy", v_t'(busy), v_t'(1));
                cnt = 0;
                for (int c = 0; c < 5; c++) begin
                    @(negedge clock);
                    if (out_valid || ifmap_end) cnt++;
                end
                chk("mc_wait_idle", v_t'(cnt), v_t'(0));
                tile_continue = 1'b1;
            end
        end
        chk("mc_ifmap_end", v_t'(ifmap_end), v_t'(1));

        // Backpressure
        start_tile(3, 1, 28, 28, 1);
        run_pass(1'b1, 1'b0, 1200);
        check_walk("bp", 0);
        chk("bp_stall_stable", v_t'(stall_bad), v_t'(0));
        chk("bp_stale_mask", v_t'(stale_bad), v_t'(0));

        // Configuration errors
        cfg_err_case("cfg_k_gt_len", 5, 1, 4);
        cfg_err_case("cfg_stride0", 3, 0, 28);

        // Asynchronous reset in the middle of a walk
        start_tile(3, 1, 28, 28, 1);
        out_ready = 1'b1;
        repeat (11) @(negedge clock);
        chk("rst_pre_valid", v_t'(out_valid), v_t'(1));
        chk("rst_pre_b10", v_t'(base_address), v_t'(exp_walk(10, 0)));
        #2 rst = 1'b1;
        #1 chk("rst_async_outs", all_outs(), v_t'(0));
        @(negedge clock);
        rst = 1'b0;
        @(negedge clock);
        start_tile(3, 1, 28, 28, 1);
        run_pass(1'b0, 1'b0, 300);
        check_walk("rst_rerun", 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/ifm_window_addr_gen.md
# ifm_window_addr_gen

Parametrised successor of the input-feature-map address generator in the mini Davinci datapath. It walks a convolution tile in raster order, one output row segment per beat, and emits one window-origin address per output pixel across `LANES` parallel lanes. It then repeats the walk for each input channel. Compared with the previous generation, it adds a ready/valid output handshake with backpressure, a runtime channel count, row- and pass-boundary tags, and configuration checking. It sits between the tile scheduler and the IFM buffer read ports.

## Interface
Parameters:
- `LANES`, 8: output pixels per beat.
- `ADDR_W`, 12: address width per lane.
- `DIM_W`, 6: width of `tile_length` and `tile_height`.
- `K_W`, 3: width of `ksize` and `stride`.
- `CH_W`, 8: width of `num_ch`.

Ports (direction, width, meaning):
- `clock` in 1: the single clock. The block has one clock.
- `rst` in 1: reset. Asynchronous and active-high.
- `tile_start` in 1: start a tile. Latches the configuration.
- `tile_continue` in 1: start the next channel pass.
- `ksize` in `K_W`: kernel size.
- `stride` in `K_W`: convolution stride.
- `tile_length` in `DIM_W`: input tile width in pixels.
- `tile_height` in `DIM_W`: input tile height in pixels.
- `num_ch` in `CH_W`: number of channel passes.
- `base_address` out `LANES*ADDR_W`: lane i occupies bits `[i*ADDR_W +: ADDR_W]`.
- `base_addr_valid` out `LANES`: lane mask.
- `out_valid` out 1 and `out_ready` in 1: beat handshake.
- `out_row_last` out 1: current beat is the last beat of an output row.
- `out_pass_last` out 1: current beat is the last beat of a channel pass.
- `addr_gen_done` out 1: one-cycle pulse at the end of each pass.
- `ifmap_end` out 1: level; all channel passes are complete.
- `cfg_err` out 1: one-cycle pulse on an illegal configuration.
- `busy` out 1: high in any state other than IDLE or END.

## Operation
- **Reset values.** All outputs are 0. State is IDLE. Reset mid-operation aborts immediately; no `addr_gen_done` is issued.
- **States and transitions:**
  - IDLE → SETUP on `tile_start` (also from END or WAIT_CONT).
  - SETUP → RUN after one cycle.
  - RUN → WAIT_CONT when the last beat of a pass is accepted and channels remain.
  - RUN → END when the last beat of the last pass is accepted.
  - WAIT_CONT → RUN when `tile_continue` is high (level-sampled).
- **Ignored inputs.** `tile_start` is ignored in SETUP and RUN. `tile_continue` is ignored outside WAIT_CONT.
- **Configuration check.** The configuration is illegal if any of these hold:
  - `ksize`, `stride` or `num_ch` is 0;
  - `ksize` > `tile_length`;
  - `ksize` > `tile_height`.
- On an illegal configuration at `tile_start`, `cfg_err` pulses the next cycle, the state returns to or stays in IDLE, and no beats are emitted.
- **SETUP.** Registers:
  - area = `tile_length * tile_height`;
  - lane offset i = `i*stride` for each lane;
  - x = 0, y = 0, row_addr = 0, ch = 0, ch_base = 0.
- **Beat contents:**
  - lane i address = `ch_base + row_addr + x + i*stride`, truncated to `ADDR_W` (modulo 2^`ADDR_W`);
  - lane i valid iff `x + i*stride + ksize <= tile_length`.
- **Advance.** Applies on accept (`out_valid && out_ready`):
  - x += `LANES*stride`;
  - if `x_next + ksize > tile_length`: the row is done, x = 0, y += `stride`, row_addr += `stride*tile_length`;
  - if `y_next + ksize > tile_height`: the pass is done.
- **Beat tags.** `out_row_last` and `out_pass_last` are computed from the same comparisons on the current beat.
- **Pass end.** ch += 1 and ch_base += area.
- **Arithmetic widths.** Position compares use `DIM_W+K_W+$clog2(LANES)+1` bits, so no overflow occurs before comparison. No divider is used. Output dimensions are implicit in the compares.
- **`ifmap_end`.** High in END and held until the next `tile_start` or `rst`.

## Timing
- **Start latency.** `tile_start` is sampled at edge N. SETUP occupies cycle N+1. `out_valid` is first high in cycle N+2.
- **Continue latency.** `tile_continue` is sampled at edge M. `out_valid` is high in cycle M+1.
- **Holding under backpressure.** While `out_valid && !out_ready`, `base_address`, `base_addr_valid` and both tags hold stable.
- **Throughput.** One beat per cycle under continuous ready.
- **`addr_gen_done`.** Pulses in the cycle after the last beat of a pass is accepted. `ifmap_end` rises in that same cycle on the final pass.
- **`out_valid` low.** Low in IDLE, SETUP, WAIT_CONT and END.
- **Stale mask.** `base_addr_valid` is 0 whenever `out_valid` is 0.
- **Start and continue together.** If `tile_start` and `tile_continue` are both high in WAIT_CONT, `tile_start` wins and the tile restarts.

## Structure
- **Package `ifm_addr_pkg`:**
  - state enum (IDLE, SETUP, RUN, WAIT_CONT, END);
  - default parameter constants;
  - a lane-slice helper function.
- **Sub-module `ifm_lane_addr`.** Holds the per-lane offset register and the address/mask generation for one lane. It is instantiated `LANES` times in a generate loop. The top level holds the FSM, counters and handshake.

## Test plan
- **Basic walk:** `LANES`=8, `ksize`=3, `stride`=1, 28×28, `num_ch`=1, ready always high.
  - 104 beats; every row is 4 beats with masks FF, FF, FF, 03.
  - Beat 0 addresses are 0–7. Beat 3 lanes 0–1 are 24 and 25.
  - Beat 4 starts at 28.
  - `addr_gen_done` fires once. `ifmap_end` = 1.
- **Stride 2:** `ksize`=2, `stride`=2, 8×8.
  - 4 beats with mask 0F.
  - Row 0 addresses 0, 2, 4, 6; row 1 addresses 16, 18, 20, 22.
  - `out_row_last` is high on every beat.
- **Multi-channel:** 28×28, `num_ch`=3, `tile_continue` pulsed 5 cycles after each `addr_gen_done`.
  - Pass 1 beat 0 is at 784; pass 2 beat 0 is at 1568.
  - `ifmap_end` is only after the third pass.
  - `tile_continue` pulses during RUN are ignored.
- **Backpressure:** random `out_ready` at 50 %.
  - Beat sequence is identical to the basic walk.
  - Outputs are stable while stalled.
  - 104 accepts total.
- **Config errors:** `ksize`=5 with `tile_length`=4, then `stride`=0.
  - `cfg_err` pulses each time, `busy` stays 0, no `out_valid`.
- **Reset mid-RUN:** assert `rst` at beat 10.
  - All outputs are 0 asynchronously.
  - A new `tile_start` reproduces beat 0 at address 0.
